// File: rtl/wfi_wake_driver_if.sv
// Handshake bundle between the WFI wake driver and the core/bench side.
// The master modport is the driver; the slave modport is the side that watches its interrupts.
interface wfi_wake_driver_if;
  logic        enable;
  logic        wfi;
  logic [1:0]  src_sel;
  logic        int_clr;
  logic        ext_int;
  logic        timer_int;
  logic        sw_int;
  logic        busy;
  logic        spurious_wake;
  logic        timeout_err;
  logic [15:0] wake_count;

  modport master (
    input  enable, wfi, src_sel, int_clr,
    output ext_int, timer_int, sw_int, busy, spurious_wake, timeout_err, wake_count
  );

  modport slave (
    output enable, wfi, src_sel, int_clr,
    input  ext_int, timer_int, sw_int, busy, spurious_wake, timeout_err, wake_count
  );
endinterface

// File: rtl/wfi_wake_driver.sv
// Raises one selected interrupt a programmable delay after the core enters WFI and holds it until cleared.
// Optional macro WFI_WAKE_RANDOM_DELAY_EN adds an LFSR-driven 0..15 cycle jitter to the delay.
//
// state | meaning
// IDLE  | waiting for an enabled wfi rise
// DELAY | counting down the wake delay, interrupt low
// WAKE  | interrupt high, waiting for wfi to fall or timeout
// CLEAR | interrupt high, waiting for int_clr from the handler
module wfi_wake_driver #(
  parameter int unsigned WAKE_DELAY   = 16,
  parameter int unsigned WAKE_TIMEOUT = 64,
  parameter logic [7:0]  LFSR_SEED    = 8'hA5
) (
  input logic             clock,
  input logic             reset,
  wfi_wake_driver_if.master bus
);

  typedef enum logic [1:0] {IDLE, DELAY, WAKE, CLEAR} state_t;

  localparam logic [15:0] TMO_LAST = 16'(WAKE_TIMEOUT - 1);

  state_t      state, state_nx;
  logic        wfi_q;
  logic [1:0]  src_q;
  logic [15:0] cnt, cnt_nx;
  logic        spur_q, spur_nx;
  logic        tmo_q, tmo_set;
  logic [15:0] wc_q;
  logic        clr_done;
  logic        load;
  logic [7:0]  load_val;
  logic        rise;

  assign rise = bus.wfi & ~wfi_q;

`ifdef WFI_WAKE_RANDOM_DELAY_EN
  logic [7:0] lfsr;
  logic [8:0] dly_sum;

  always_ff @(posedge clock) begin
    if (reset)
      lfsr <= LFSR_SEED;
    else if (bus.enable)
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

  assign dly_sum  = 9'(WAKE_DELAY) + {5'd0, lfsr[3:0]};
  assign load_val = (dly_sum > 9'd255) ? 8'hFF : dly_sum[7:0];
`else
  // The seed only matters when the random-delay LFSR is built.
  logic unused_seed;
  assign unused_seed = ^LFSR_SEED;
  assign load_val    = 8'(WAKE_DELAY);
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      wfi_q  <= 1'b0;
      src_q  <= 2'd0;
      cnt    <= 16'd0;
      spur_q <= 1'b0;
      tmo_q  <= 1'b0;
      wc_q   <= 16'd0;
    end else begin
      state  <= state_nx;
      wfi_q  <= bus.wfi;
      cnt    <= cnt_nx;
      spur_q <= spur_nx;
      if (load)
        src_q <= bus.src_sel;
      if (tmo_set)
        tmo_q <= 1'b1;
      if (clr_done && wc_q != 16'hFFFF)
        wc_q <= wc_q + 16'd1;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    spur_nx  = 1'b0;
    tmo_set  = 1'b0;
    clr_done = 1'b0;
    load     = 1'b0;
    if (!bus.enable) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (rise) begin
            state_nx = DELAY;
            cnt_nx   = {8'd0, load_val};
            load     = 1'b1;
          end
        end
        DELAY: begin
          if (!bus.wfi) begin
            state_nx = IDLE;
            spur_nx  = 1'b1;
          end else if (cnt == 16'd0) begin
            state_nx = WAKE;
            cnt_nx   = 16'd0;
          end else begin
            cnt_nx = cnt - 16'd1;
          end
        end
        WAKE: begin
          // wfi falling takes priority over a simultaneous timeout
          if (!bus.wfi) begin
            state_nx = CLEAR;
          end else if (cnt == TMO_LAST) begin
            state_nx = IDLE;
            tmo_set  = 1'b1;
          end else begin
            cnt_nx = cnt + 16'd1;
          end
        end
        CLEAR: begin
          if (bus.int_clr) begin
            state_nx = IDLE;
            clr_done = 1'b1;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_comb begin
    bus.ext_int   = 1'b0;
    bus.timer_int = 1'b0;
    bus.sw_int    = 1'b0;
    if (state == WAKE || state == CLEAR) begin
      case (src_q)
        2'd0:    bus.ext_int   = 1'b1;
        2'd1:    bus.timer_int = 1'b1;
        2'd2:    bus.sw_int    = 1'b1;
        default: ;
      endcase
    end
    bus.busy          = (state != IDLE);
    bus.spurious_wake = spur_q;
    bus.timeout_err   = tmo_q;
    bus.wake_count    = wc_q;
  end

endmodule

// File: tb/tb_wfi_wake_driver.sv
// Directed bench for wfi_wake_driver with a scoreboard of expected wake latencies.
`ifdef WFI_WAKE_RANDOM_DELAY_EN
`define RND(l) int'(l[3:0])
`else
`define RND(l) 0
`endif

module tb_wfi_wake_driver;
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  wfi_wake_driver_if i0();
  wfi_wake_driver_if i1();

  wfi_wake_driver #(.WAKE_DELAY(16), .WAKE_TIMEOUT(64), .LFSR_SEED(8'hA5)) dut0 (
    .clock(clock), .reset(reset), .bus(i0.master));
  wfi_wake_driver #(.WAKE_DELAY(0), .WAKE_TIMEOUT(8), .LFSR_SEED(8'hA5)) dut1 (
    .clock(clock), .reset(reset), .bus(i1.master));

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t_rise[2];

  typedef struct { string tag; logic [2:0] line; int lat; } exp_t;
  exp_t sb[$];

  // reference LFSR: 8-bit Fibonacci, taps 8,6,5,4, steps while enable is high
  function automatic logic [7:0] lfsr_step(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  logic [7:0] m0, m1;
  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (reset) begin
      m0 <= 8'hA5;
      m1 <= 8'hA5;
    end else begin
      if (i0.enable) m0 <= lfsr_step(m0);
      if (i1.enable) m1 <= lfsr_step(m1);
    end
  end

  function automatic logic [2:0] lines(input int d);
    return (d == 0) ? {i0.ext_int, i0.timer_int, i0.sw_int}
                    : {i1.ext_int, i1.timer_int, i1.sw_int};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // drive a wfi rise at the current negedge and push the expected wake
  task automatic rise(input int d, input logic [2:0] line, input int base, input string tag);
    exp_t e;
    int dl;
    if (d == 0) begin
      i0.wfi = 1'b1;
      dl = base + `RND(m0);
    end else begin
      i1.wfi = 1'b1;
      dl = base + `RND(m1);
    end
    if (dl > 255) dl = 255;
    e.tag  = tag;
    e.line = line;
    e.lat  = dl + 1;
    sb.push_back(e);
    t_rise[d] = cyc + 1;
  endtask

  task automatic wait_line(input int d, output int lat);
    exp_t e;
    logic [2:0] v;
    int n;
    v = 3'b000;
    n = 0;
    while (n < 400) begin
      @(negedge clock);
      n++;
      v = lines(d);
      if (v != 3'b000) break;
    end
    if (v == 3'b000) chk("wait_line_expired", 32'd0, 32'd1);
    lat = cyc - t_rise[d];
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk({e.tag, "_latency"}, lat, e.lat);
      chk({e.tag, "_line"}, {29'd0, v}, {29'd0, e.line});
    end
  endtask

  task automatic pulse_clr(input int d);
    if (d == 0) i0.int_clr = 1'b1; else i1.int_clr = 1'b1;
    @(negedge clock);
    i0.int_clr = 1'b0;
    i1.int_clr = 1'b0;
  endtask

  initial begin
    int lat;
    int n;
    reset = 1'b1;
    i0.enable = 1'b0; i0.wfi = 1'b0; i0.src_sel = 2'd0; i0.int_clr = 1'b0;
    i1.enable = 1'b0; i1.wfi = 1'b0; i1.src_sel = 2'd0; i1.int_clr = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_lines", {29'd0, lines(0)}, 32'd0);
    chk("rst_busy", {31'd0, i0.busy}, 32'd0);
    chk("rst_spurious", {31'd0, i0.spurious_wake}, 32'd0);
    chk("rst_timeout", {31'd0, i0.timeout_err}, 32'd0);
    chk("rst_count", {16'd0, i0.wake_count}, 32'd0);
    reset = 1'b0;
    i0.enable = 1'b1;
    i1.enable = 1'b1;
    @(negedge clock);

    // basic timer wake
    i0.src_sel = 2'd1;
    rise(0, 3'b010, 16, "basic");
    repeat (2) @(negedge clock);
    chk("basic_busy", {31'd0, i0.busy}, 32'd1);
    wait_line(0, lat);
    repeat (3) @(negedge clock);
    i0.wfi = 1'b0;
    @(negedge clock);
    chk("basic_hold_in_clear", {29'd0, lines(0)}, 32'd2);
    repeat (4) @(negedge clock);
    pulse_clr(0);
    chk("basic_release", {29'd0, lines(0)}, 32'd0);
    chk("basic_count", {16'd0, i0.wake_count}, 32'd1);
    chk("basic_idle", {31'd0, i0.busy}, 32'd0);

    // int_clr during DELAY is ignored
    @(negedge clock);
    i0.src_sel = 2'd2;
    rise(0, 3'b001, 16, "clr_in_delay");
    repeat (3) @(negedge clock);
    pulse_clr(0);
    wait_line(0, lat);
    chk("clr_in_delay_count", {16'd0, i0.wake_count}, 32'd1);
    i0.wfi = 1'b0;
    @(negedge clock);
    pulse_clr(0);
    chk("clr_in_delay_count2", {16'd0, i0.wake_count}, 32'd2);

    // spurious wake: wfi low at cycle 5
    @(negedge clock);
    i0.src_sel = 2'd0;
    i0.wfi = 1'b1;
    repeat (5) @(negedge clock);
    i0.wfi = 1'b0;
    @(negedge clock);
    chk("spur_pulse", {31'd0, i0.spurious_wake}, 32'd1);
    chk("spur_busy", {31'd0, i0.busy}, 32'd0);
    chk("spur_lines", {29'd0, lines(0)}, 32'd0);
    @(negedge clock);
    chk("spur_one_cycle", {31'd0, i0.spurious_wake}, 32'd0);

    // wfi falls on the timeout edge: CLEAR wins, no error
    @(negedge clock);
    rise(0, 3'b100, 16, "edge_tmo");
    wait_line(0, lat);
    repeat (63) @(negedge clock);
    i0.wfi = 1'b0;
    @(negedge clock);
    chk("edge_tmo_hold", {29'd0, lines(0)}, 32'd4);
    chk("edge_tmo_noerr", {31'd0, i0.timeout_err}, 32'd0);
    pulse_clr(0);
    chk("edge_tmo_count", {16'd0, i0.wake_count}, 32'd3);

    // timeout: ext_int high for exactly 64 cycles
    @(negedge clock);
    rise(0, 3'b100, 16, "timeout");
    wait_line(0, lat);
    n = 1;
    while (n < 200) begin
      @(negedge clock);
      if (!i0.ext_int) break;
      n++;
    end
    chk("timeout_len", n, 32'd64);
    chk("timeout_err", {31'd0, i0.timeout_err}, 32'd1);
    chk("timeout_idle", {31'd0, i0.busy}, 32'd0);
    i0.wfi = 1'b0;
    @(negedge clock);

    // timeout_err stays set through a later wake
    i0.src_sel = 2'd1;
    rise(0, 3'b010, 16, "sticky");
    wait_line(0, lat);
    i0.wfi = 1'b0;
    @(negedge clock);
    pulse_clr(0);
    chk("sticky_err", {31'd0, i0.timeout_err}, 32'd1);
    chk("sticky_count", {16'd0, i0.wake_count}, 32'd4);

    // enable abort during WAKE
    @(negedge clock);
    i0.src_sel = 2'd2;
    rise(0, 3'b001, 16, "abort");
    wait_line(0, lat);
    repeat (2) @(negedge clock);
    i0.enable = 1'b0;
    @(negedge clock);
    chk("abort_lines", {29'd0, lines(0)}, 32'd0);
    chk("abort_busy", {31'd0, i0.busy}, 32'd0);
    chk("abort_count", {16'd0, i0.wake_count}, 32'd4);
    i0.wfi = 1'b0;
    @(negedge clock);
    i0.enable = 1'b1;
    @(negedge clock);

    // zero delay on dut1: sw_int at cycle 1
    i1.src_sel = 2'd2;
    rise(1, 3'b001, 0, "zero_delay");
    wait_line(1, lat);
    i1.wfi = 1'b0;
    @(negedge clock);
    pulse_clr(1);
    chk("zero_delay_count", {16'd0, i1.wake_count}, 32'd1);

    // synchronous reset during CLEAR
    @(negedge clock);
    i1.src_sel = 2'd0;
    rise(1, 3'b100, 0, "rst_clear");
    wait_line(1, lat);
    i1.wfi = 1'b0;
    @(negedge clock);
    chk("rst_clear_hold", {29'd0, lines(1)}, 32'd4);
    reset = 1'b1;
    @(negedge clock);
    chk("rst_clear_lines", {29'd0, lines(1)}, 32'd0);
    chk("rst_clear_count", {16'd0, i1.wake_count}, 32'd0);
    chk("rst_clear_busy", {31'd0, i1.busy}, 32'd0);
    reset = 1'b0;
    @(negedge clock);

`ifdef WFI_WAKE_RANDOM_DELAY_EN
    // random delay: 100 back-to-back wakes checked against the LFSR model
    for (int k = 0; k < 100; k++) begin
      @(negedge clock);
      i0.src_sel = 2'd1;
      rise(0, 3'b010, 16, "rand");
      wait_line(0, lat);
      chk("rand_range", {31'd0, (lat >= 17 && lat <= 32)}, 32'd1);
      i0.wfi = 1'b0;
      @(negedge clock);
      pulse_clr(0);
    end
    chk("rand_count", {16'd0, i0.wake_count}, 32'd100);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
